cpu_load_store_unit: RTL
========================

# cpu_load_store_unit

Load/store unit between the execute stage and the data port (port B) of the CPU bus arbiter. Converts byte, halfword and word loads and stores into aligned 32-bit bus transactions. The bus has no byte enables, so sub-word stores are done as read-modify-write sequences. Loads are sign- or zero-extended. Both sides use a request/ready handshake.

## Interface
Parameters:
- none

Ports:
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_request  in  1  execute-stage access request; held until o_ready
- i_rw  in  1  0 = load, 1 = store
- i_width  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- i_signed  in  1  sign-extend sub-word load (ignored for stores and words)
- i_address  in  32  byte address
- i_wdata  in  32  store data, right-justified
- o_ready  out  1  one-cycle completion pulse
- o_rdata  out  32  load result, valid while o_ready is high; otherwise holds its last value
- o_fault  out  1  misaligned access; only with CPU_LSU_MISALIGN_TRAP_EN
- o_bus_rw  out  1  bus direction to arbiter port B
- o_bus_request  out  1  bus request to arbiter port B
- i_bus_ready  in  1  arbiter port B ready
- o_bus_address  out  32  word-aligned bus address
- i_bus_rdata  in  32  bus read data
- o_bus_wdata  out  32  bus write data

## Operation
- All outputs are registered.
- Reset value of every output is 0. State resets to IDLE.
- Request fields are latched in IDLE when i_request=1. The inputs are ignored after that until the next IDLE.
- o_bus_address is {addr[31:2], 2'b00}.
- Lanes are little-endian. The byte lane is addr[1:0]. The halfword lane is addr[1].
- Misaligned access:
  - half with addr[0]=1
  - word with addr[1:0]≠0
- States and transitions:
  - IDLE:
    - load → RD
    - word store → WR
    - byte/half store → RD
    - misaligned access with the macro enabled → DONE, with o_fault=1 and no bus access
  - RD: o_bus_request=1, o_bus_rw=0. When i_bus_ready=1, capture i_bus_rdata, then:
    - load → DONE
    - store → MERGE
  - MERGE: o_bus_request=0. Form o_bus_wdata by replacing the addressed lane of the captured word with i_wdata[7:0] (byte) or i_wdata[15:0] (half). Go to WR.
  - WR: o_bus_request=1, o_bus_rw=1. When i_bus_ready=1 → DONE.
  - DONE: o_ready=1 for exactly one cycle. For a load, o_rdata = extracted lane, zero- or sign-extended per i_signed. Go to IDLE.
- o_fault is asserted only in DONE, together with o_ready. It is 0 in every other cycle.
- Stores leave o_rdata unchanged.
- Bus address, rw and wdata stay stable while o_bus_request=1.
- o_bus_request always drops for at least one cycle after i_bus_ready. This lets the arbiter return to idle before the next request is sampled.

## Timing
- Let N be the first cycle in IDLE with i_request=1. Bus request asserts at N+1.
- With a bus ready after k wait cycles:
  - load / word store: o_ready at N+2+k
  - RMW store: o_ready at N+4+k1+k2 (k1 = read wait cycles, k2 = write wait cycles)
  - fault: o_ready at N+1
- If i_request is still high in the cycle after o_ready, it is a new transaction. The requester deasserts it in that cycle.
- i_bus_ready is ignored when o_bus_request=0.
- Reset mid-operation:
  - The next state is IDLE and all outputs are 0. No o_ready is produced.
  - A partially completed RMW is abandoned. The read may have happened; the write has not.

## Configuration
- CPU_LSU_MISALIGN_TRAP_EN defined: a misaligned access issues no bus request and completes with o_ready=1, o_fault=1. o_rdata is unchanged.
- Not defined: o_fault is tied to 0. Misaligned addresses are silently aligned down: half ignores addr[0]; word ignores addr[1:0].

## Test plan
- Load byte, unsigned, addr 0x1003, bus word 0x8899AABB → one bus read at 0x1000; o_rdata=0x00000088 with o_ready.
- Load byte, signed, same access → o_rdata=0xFFFFFF88. Load half, signed, addr 0x1000 → o_rdata=0xFFFFAABB.
- Store half 0x00001234 at 0x2002, memory word 0xDEADBEEF → read 0x2000, one cycle with request low, then write 0x2000 with wdata 0x1234BEEF; o_ready once.
- Store word 0xCAFEF00D at 0x3000, bus ready delayed 3 cycles → single write, no read; o_ready at N+5.
- Load word at 0x1001:
  - with the macro → o_ready and o_fault at N+1, no bus request
  - without the macro → bus read at 0x1000
- Assert reset during MERGE of a byte store → next cycle all outputs 0 and no write issued; a following load completes normally.

Source files
------------

// File: rtl/cpu_load_store_unit_if.sv
// Bus-side signal bundle between the load/store unit and arbiter port B.
// master = load/store unit, slave = arbiter port B.
interface cpu_load_store_unit_if;
  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_bus_wdata;

  modport master (
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    input  i_bus_ready, i_bus_rdata
  );

  modport slave (
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    output i_bus_ready, i_bus_rdata
  );
endinterface

// File: rtl/cpu_load_store_unit.sv
// Load/store unit: byte/half/word accesses over a 32-bit bus without byte enables.
// Optional macro CPU_LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of aligning down.
module cpu_load_store_unit (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_request,
  input  logic                         i_rw,
  input  logic [1:0]                   i_width,
  input  logic                         i_signed,
  input  logic [31:0]                  i_address,
  input  logic [31:0]                  i_wdata,
  output logic                         o_ready,
  output logic [31:0]                  o_rdata,
  output logic                         o_fault,
  cpu_load_store_unit_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_rw;
  logic [1:0]  r_width;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_word;

  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

`ifdef CPU_LSU_MISALIGN_TRAP_EN
  assign w_misaligned = ((i_width == 2'd1) && i_address[0]) ||
                        (i_width[1] && (i_address[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // Lane extraction reads the bus directly so o_rdata is ready with o_ready.
  always_comb begin
    w_byte = bus.i_bus_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = bus.i_bus_rdata[7:0];
      2'd1: w_byte = bus.i_bus_rdata[15:8];
      2'd2: w_byte = bus.i_bus_rdata[23:16];
      2'd3: w_byte = bus.i_bus_rdata[31:24];
      default: w_byte = bus.i_bus_rdata[7:0];
    endcase
    w_half = r_lane[1] ? bus.i_bus_rdata[31:16] : bus.i_bus_rdata[15:0];
    case (r_width)
      2'd0:    w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load_val = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_val = bus.i_bus_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_word;
    if (r_width == 2'd0) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = r_word;
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_rw              <= 1'b0;
      r_width           <= '0;
      r_signed          <= 1'b0;
      r_lane            <= '0;
      r_wdata           <= '0;
      r_word            <= '0;
      o_ready           <= 1'b0;
      o_rdata           <= '0;
      o_fault           <= 1'b0;
      bus.o_bus_rw      <= 1'b0;
      bus.o_bus_request <= 1'b0;
      bus.o_bus_address <= '0;
      bus.o_bus_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_request) begin
            r_rw              <= i_rw;
            r_width           <= i_width;
            r_signed          <= i_signed;
            r_lane            <= i_address[1:0];
            r_wdata           <= i_wdata[15:0];
            bus.o_bus_address <= {i_address[31:2], 2'b00};
            if (w_misaligned) begin
              o_ready <= 1'b1;
              o_fault <= 1'b1;
              r_state <= S_DONE;
            end else if (i_rw && i_width[1]) begin
              bus.o_bus_rw      <= 1'b1;
              bus.o_bus_wdata   <= i_wdata;
              bus.o_bus_request <= 1'b1;
              r_state           <= S_WR;
            end else begin
              bus.o_bus_rw      <= 1'b0;
              bus.o_bus_request <= 1'b1;
              r_state           <= S_RD;
            end
          end
        end
        S_RD: begin
          if (bus.i_bus_ready) begin
            bus.o_bus_request <= 1'b0;
            r_word            <= bus.i_bus_rdata;
            if (r_rw) begin
              r_state <= S_MERGE;
            end else begin
              o_ready <= 1'b1;
              o_rdata <= w_load_val;
              r_state <= S_DONE;
            end
          end
        end
        S_MERGE: begin
          bus.o_bus_wdata   <= w_merged;
          bus.o_bus_rw      <= 1'b1;
          bus.o_bus_request <= 1'b1;
          r_state           <= S_WR;
        end
        S_WR: begin
          if (bus.i_bus_ready) begin
            bus.o_bus_request <= 1'b0;
            o_ready           <= 1'b1;
            r_state           <= S_DONE;
          end
        end
        S_DONE: begin
          o_ready <= 1'b0;
          o_fault <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
